// File: rtl/readout_sequencer.sv
// Frame controller for the pixel array: exposure, settle, then serial shift-out of
// every pixel counter onto a valid/ready stream. Optional macro: PATTERN_INJECT_EN.
module readout_sequencer #(
    parameter int Row    = 3,
    parameter int Col    = 3,
    parameter int CNT_W  = 12,
    parameter int SHUT_W = 16,
    parameter int SETTLE = 4
) (
    input  logic               readClk,
    input  logic               resetN,
    input  logic               start,
    input  logic               abort,
    input  logic [SHUT_W-1:0]  shutterLen,
    input  logic               sumModeCfg,
    output logic               busy,
    output logic               done,
    output logic               shutter,
    output logic               sumMode,
    output logic               shiftEn,
    output logic [Col-1:0]     SerInA,
    output logic [Col-1:0]     SerInB,
    input  logic [Col-1:0]     SerOutA,
    input  logic [Col-1:0]     SerOutB,
    output logic [2*Col-1:0]   outData,
    output logic               outValid,
    input  logic               outReady,
    output logic               outLast
);
    localparam int N      = Row * CNT_W;
    localparam int BEAT_W = $clog2(N + 1);
    localparam int SET_W  = 8;

    typedef enum logic [2:0] {
        S_IDLE, S_EXPOSE, S_SETTLE, S_SHIFT, S_DRAIN, S_DONE
    } state_t;

    state_t              state_reg;
    logic [SHUT_W-1:0]   exp_cnt_reg;
    logic [SET_W-1:0]    settle_cnt_reg;
    logic [BEAT_W-1:0]   beat_cnt_reg;
    logic                fire;

    // A beat fires whenever the output slot is free or being emptied this cycle;
    // abort suppresses the shift so the chains do not advance on the cancelling edge.
    assign fire    = (state_reg == S_SHIFT) && (!outValid || outReady) && !abort;
    assign shiftEn = fire;
    assign busy    = (state_reg != S_IDLE);

`ifdef PATTERN_INJECT_EN
    assign SerInA = fire ? {Col{beat_cnt_reg[0]}} : '0;
    assign SerInB = fire ? ~{Col{beat_cnt_reg[0]}} : '0;
`else
    assign SerInA = '0;
    assign SerInB = '0;
`endif

    always_ff @(posedge readClk or negedge resetN) begin
        if (!resetN) begin
            state_reg      <= S_IDLE;
            exp_cnt_reg    <= '0;
            settle_cnt_reg <= '0;
            beat_cnt_reg   <= '0;
            shutter        <= 1'b0;
            sumMode        <= 1'b0;
            outData        <= '0;
            outValid       <= 1'b0;
            outLast        <= 1'b0;
            done           <= 1'b0;
        end else if (abort) begin
            state_reg      <= S_IDLE;
            exp_cnt_reg    <= '0;
            settle_cnt_reg <= '0;
            beat_cnt_reg   <= '0;
            shutter        <= 1'b0;
            outValid       <= 1'b0;
            outLast        <= 1'b0;
            done           <= 1'b0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        state_reg   <= S_EXPOSE;
                        shutter     <= 1'b1;
                        sumMode     <= sumModeCfg;
                        exp_cnt_reg <= (shutterLen == '0) ? SHUT_W'(1) : shutterLen;
                    end
                end
                S_EXPOSE: begin
                    // exp_cnt_reg counts the shutter-high cycles still to go, including this one
                    if (exp_cnt_reg <= SHUT_W'(1)) begin
                        shutter        <= 1'b0;
                        state_reg      <= S_SETTLE;
                        settle_cnt_reg <= '0;
                    end else begin
                        exp_cnt_reg <= exp_cnt_reg - SHUT_W'(1);
                    end
                end
                S_SETTLE: begin
                    if (settle_cnt_reg == SET_W'(SETTLE - 1)) begin
                        state_reg    <= S_SHIFT;
                        beat_cnt_reg <= '0;
                    end else begin
                        settle_cnt_reg <= settle_cnt_reg + SET_W'(1);
                    end
                end
                S_SHIFT: begin
                    if (fire) begin
                        outData      <= {SerOutB, SerOutA};
                        outValid     <= 1'b1;
                        outLast      <= (beat_cnt_reg == BEAT_W'(N - 1));
                        beat_cnt_reg <= beat_cnt_reg + BEAT_W'(1);
                        if (beat_cnt_reg == BEAT_W'(N - 1))
                            state_reg <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (outValid && outReady) begin
                        outValid  <= 1'b0;
                        outLast   <= 1'b0;
                        done      <= 1'b1;
                        state_reg <= S_DONE;
                    end
                end
                S_DONE: begin
                    done      <= 1'b0;
                    state_reg <= S_IDLE;
                end
                default: state_reg <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_readout_sequencer.sv
// Self-checking bench for readout_sequencer: a bit-level pixel array model feeds the
// chains, and each frame is predicted from the exposure/settle/stream rules.
module tb_readout_sequencer;
    localparam int Row    = 3;
    localparam int Col    = 3;
    localparam int CNT_W  = 12;
    localparam int SHUT_W = 16;
    localparam int SETTLE = 4;
    localparam int N      = Row * CNT_W;

    logic               readClk = 1'b0;
    logic               resetN;
    logic               start, abort, sumModeCfg, outReady;
    logic [SHUT_W-1:0]  shutterLen;
    logic               busy, done, shutter, sumMode, shiftEn, outValid, outLast;
    logic [Col-1:0]     SerInA, SerInB, SerOutA, SerOutB;
    logic [2*Col-1:0]   outData;

    int checks = 0;
    int fails  = 0;

    logic [N-1:0] chain_a [Col];
    logic [N-1:0] chain_b [Col];
    logic [N-1:0] fill_a  [Col];
    logic [N-1:0] fill_b  [Col];
    logic         fill_req = 1'b0;
    int           n_shifts = 0;

    always #5 readClk = ~readClk;

    // Pixel array: one N-bit chain per column and side, output at the far end.
    always @(posedge readClk) begin
        if (fill_req) begin
            for (int c = 0; c < Col; c++) begin
                chain_a[c] <= fill_a[c];
                chain_b[c] <= fill_b[c];
            end
        end else if (shiftEn) begin
            for (int c = 0; c < Col; c++) begin
                chain_a[c] <= {chain_a[c][N-2:0], SerInA[c]};
                chain_b[c] <= {chain_b[c][N-2:0], SerInB[c]};
            end
            n_shifts <= n_shifts + 1;
        end
    end

    for (genvar gi = 0; gi < Col; gi++) begin : g_out
        assign SerOutA[gi] = chain_a[gi][N-1];
        assign SerOutB[gi] = chain_b[gi][N-1];
    end

    readout_sequencer #(.Row(Row), .Col(Col), .CNT_W(CNT_W), .SHUT_W(SHUT_W), .SETTLE(SETTLE)) dut (
        .readClk(readClk), .resetN(resetN), .start(start), .abort(abort),
        .shutterLen(shutterLen), .sumModeCfg(sumModeCfg), .busy(busy), .done(done),
        .shutter(shutter), .sumMode(sumMode), .shiftEn(shiftEn),
        .SerInA(SerInA), .SerInB(SerInB), .SerOutA(SerOutA), .SerOutB(SerOutB),
        .outData(outData), .outValid(outValid), .outReady(outReady), .outLast(outLast)
    );

    function automatic logic pick_ready(input int mode, input int cyc);
        if (mode == 0) return 1'b1;
        if (mode == 1) return (cyc % 4 == 0) || (cyc % 4 == 3);
        return 1'($urandom);
    endfunction

    task automatic fill_array();
        logic [63:0] r;
        @(negedge readClk);
        for (int c = 0; c < Col; c++) begin
            r = {$urandom, $urandom};
            fill_a[c] = r[N-1:0];
            r = {$urandom, $urandom};
            fill_b[c] = r[N-1:0];
        end
        fill_req = 1'b1;
        @(negedge readClk);
        fill_req = 1'b0;
    endtask

    // Runs one frame from IDLE; called on a negedge. abort_after < 0 means no abort.
    task automatic run_frame(input string name, input int len, input bit sum_cfg,
                             input int mode, input int abort_after, input bit pat_chk);
        logic [2*Col-1:0] exp_q[$];
        logic [2*Col-1:0] b;
        logic [2*Col-1:0] pat;
        logic [2*Col-1:0] exp_ser;
        int  l_eff, f, acc, hs_last, shifts0;
        bit  slot, rdy, ab, aborted, shift_ph, exp_fire, hs;
        l_eff = (len == 0) ? 1 : len;
        for (int k = 0; k < N; k++) begin
            for (int c = 0; c < Col; c++) begin
                b[c]       = chain_a[c][N-1-k];
                b[Col + c] = chain_b[c][N-1-k];
            end
            exp_q.push_back(b);
        end
        shifts0 = n_shifts;
        start = 1'b1; abort = 1'b0; shutterLen = SHUT_W'(len); sumModeCfg = sum_cfg;
        outReady = pick_ready(mode, 0);
        #1;
        checks++;
        if ({busy, outValid, shutter} !== 3'b000) begin
            fails++; $display("FAIL %s idle_before_start: got %b expected 000", name, {busy, outValid, shutter});
        end
        f = 0; acc = 0; hs_last = -1; slot = 1'b0; aborted = 1'b0;
        for (int cyc = 1; ; cyc++) begin
            @(negedge readClk);
            if (cyc > 800) begin
                checks++; fails++;
                $display("FAIL %s timeout: got %0d beats accepted expected %0d", name, acc, N);
                break;
            end
            start      = (cyc <= l_eff) ? 1'($urandom) : 1'b0;
            shutterLen = SHUT_W'($urandom);
            sumModeCfg = 1'($urandom);
            rdy        = pick_ready(mode, cyc);
            outReady   = rdy;
            shift_ph   = (cyc >= l_eff + SETTLE + 1);
            ab         = (abort_after >= 0) && shift_ph && (f == abort_after) && !aborted;
            abort      = ab;
            #1;
            if (aborted) begin
                checks++;
                if ({busy, done, shutter, shiftEn, outValid, outLast} !== 6'b0) begin
                    fails++; $display("FAIL %s abort_idle: got %b expected 000000", name,
                                      {busy, done, shutter, shiftEn, outValid, outLast});
                end
                break;
            end
            if (hs_last >= 0 && cyc == hs_last + 2) begin
                checks++;
                if ({busy, done, outValid, shiftEn} !== 4'b0) begin
                    fails++; $display("FAIL %s frame_end: got %b expected 0000", name, {busy, done, outValid, shiftEn});
                end
                checks++;
                if (n_shifts - shifts0 !== N) begin
                    fails++; $display("FAIL %s shift_count: got %0d expected %0d", name, n_shifts - shifts0, N);
                end
                break;
            end
            exp_fire = shift_ph && !ab && (f < N) && (!slot || rdy);
            checks++;
            if (shutter !== (cyc <= l_eff)) begin
                fails++; $display("FAIL %s shutter cyc %0d: got %b expected %b", name, cyc, shutter, cyc <= l_eff);
            end
            if (!ab) begin
                checks++;
                if (shiftEn !== exp_fire) begin
                    fails++; $display("FAIL %s shiftEn cyc %0d: got %b expected %b", name, cyc, shiftEn, exp_fire);
                end
            end
            checks++;
            if (outValid !== slot) begin
                fails++; $display("FAIL %s outValid cyc %0d: got %b expected %b", name, cyc, outValid, slot);
            end
            checks++;
            if (busy !== 1'b1 || done !== (hs_last >= 0 && cyc == hs_last + 1)) begin
                fails++; $display("FAIL %s busy_done cyc %0d: got %b%b expected 1%b", name, cyc, busy, done,
                                  hs_last >= 0 && cyc == hs_last + 1);
            end
            checks++;
            if (sumMode !== sum_cfg) begin
                fails++; $display("FAIL %s sumMode cyc %0d: got %b expected %b", name, cyc, sumMode, sum_cfg);
            end
`ifdef PATTERN_INJECT_EN
            exp_ser = exp_fire ? {~{Col{f[0]}}, {Col{f[0]}}} : '0;
`else
            exp_ser = '0;
`endif
            if (!ab) begin
                checks++;
                if ({SerInB, SerInA} !== exp_ser) begin
                    fails++; $display("FAIL %s serin cyc %0d: got %h expected %h", name, cyc, {SerInB, SerInA}, exp_ser);
                end
            end
            if (slot) begin
                checks++;
                if (outData !== exp_q[acc] || outLast !== (acc == N - 1)) begin
                    fails++; $display("FAIL %s beat %0d: got data %h last %b expected data %h last %b",
                                      name, acc, outData, outLast, exp_q[acc], acc == N - 1);
                end
                if (pat_chk) begin
                    pat = {~{Col{acc[0]}}, {Col{acc[0]}}};
                    checks++;
                    if (outData !== pat) begin
                        fails++; $display("FAIL %s pattern beat %0d: got %h expected %h", name, acc, outData, pat);
                    end
                end
            end
            if (ab) begin
                aborted = 1'b1;
            end else begin
                hs = slot && rdy;
                if (hs) begin
                    acc++;
                    if (acc == N) hs_last = cyc;
                end
                if (exp_fire) begin
                    f++;
                    slot = 1'b1;
                end else if (hs) begin
                    slot = 1'b0;
                end
            end
        end
        start = 1'b0;
        abort = 1'b0;
        $display("frame %s: len=%0d sum=%0d beats_accepted=%0d", name, len, sum_cfg, acc);
    endtask

    task automatic test_reset();
        resetN = 1'b0; start = 1'b0; abort = 1'b0; outReady = 1'b0;
        shutterLen = '0; sumModeCfg = 1'b0;
        @(negedge readClk); #1;
        checks++;
        if ({busy, done, shutter, sumMode, shiftEn, outValid, outLast} !== 7'b0 || outData !== '0) begin
            fails++; $display("FAIL reset_values: got %b data %h expected all zero",
                              {busy, done, shutter, sumMode, shiftEn, outValid, outLast}, outData);
        end
        @(negedge readClk);
        resetN = 1'b1;
        $display("reset: released");
    endtask

    task automatic test_basic_frame();
        fill_array();
        run_frame("basic", 5, 1'b1, 0, -1, 1'b0);
    endtask

    task automatic test_zero_shutter();
        fill_array();
        run_frame("zero_shutter", 0, 1'b0, 0, -1, 1'b0);
    endtask

    task automatic test_backpressure();
        fill_array();
        run_frame("backpressure", 3, 1'b1, 1, -1, 1'b0);
    endtask

    task automatic test_random_ready();
        for (int i = 0; i < 2; i++) begin
            fill_array();
            run_frame("random_ready", int'($urandom_range(1, 12)), 1'($urandom), 2, -1, 1'b0);
        end
    endtask

    task automatic test_abort();
        fill_array();
        run_frame("abort", 4, 1'b0, 0, 10, 1'b0);
    endtask

    task automatic test_back_to_back();
        fill_array();
        run_frame("after_abort", 2, 1'b1, 0, -1, 1'b0);
        run_frame("back_to_back", 1, 1'b0, 2, -1, 1'b0);
    endtask

    task automatic test_start_abort_idle();
        @(negedge readClk);
        start = 1'b1; abort = 1'b1;
        @(negedge readClk);
        start = 1'b0; abort = 1'b0;
        #1;
        checks++;
        if ({busy, shutter} !== 2'b00) begin
            fails++; $display("FAIL start_abort_idle: got busy/shutter %b expected 00", {busy, shutter});
        end
        $display("start_abort_idle: busy=%b", busy);
    endtask

    task automatic test_async_reset();
        fill_array();
        start = 1'b1; shutterLen = SHUT_W'(10); sumModeCfg = 1'b1;
        repeat (3) @(negedge readClk);
        start = 1'b0;
        #1;
        checks++;
        if (shutter !== 1'b1) begin
            fails++; $display("FAIL expose_shutter: got %b expected 1", shutter);
        end
        resetN = 1'b0;
        #1;
        checks++;
        if ({busy, done, shutter, sumMode, shiftEn, outValid, outLast} !== 7'b0 || outData !== '0) begin
            fails++; $display("FAIL async_reset: got %b data %h expected all zero",
                              {busy, done, shutter, sumMode, shiftEn, outValid, outLast}, outData);
        end
        #2;
        resetN = 1'b1;
        @(negedge readClk); #1;
        checks++;
        if ({busy, shutter} !== 2'b00) begin
            fails++; $display("FAIL post_reset_idle: got %b expected 00", {busy, shutter});
        end
        $display("async_reset: shutter=%b busy=%b", shutter, busy);
    endtask

`ifdef PATTERN_INJECT_EN
    task automatic test_pattern();
        fill_array();
        run_frame("pattern_fill", 3, 1'b1, 0, -1, 1'b0);
        run_frame("pattern_read", 1, 1'b0, 2, -1, 1'b1);
    endtask
`endif

    initial begin
        #300000;
        $display("FAIL watchdog: got no summary expected end of test");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_basic_frame();
        test_zero_shutter();
        test_backpressure();
        test_random_ready();
        test_abort();
        test_back_to_back();
        test_start_abort_idle();
        test_async_reset();
`ifdef PATTERN_INJECT_EN
        test_pattern();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule

// File: doc/readout_sequencer.md
Name: readout_sequencer

Overview:
- Frame controller for the digital front-end pixel array (Row x Col, two serial chains A/B per column).
- Sequences each frame: exposure (shutter), settle, then a serial shift-out of every pixel counter.
- Latches summing mode per frame.
- Repacks the two chain outputs into Col-wide beats on a valid/ready stream toward the readout link; shifting stalls whenever the stream backpressures.

Parameters:
- Row, 3, pixel rows per column chain.
- Col, 3, pixel columns (chain count per A/B side).
- CNT_W, 12, counter bits per pixel; total beats per frame N = Row*CNT_W.
- SHUT_W, 16, width of exposure-length field.
- SETTLE, 4, idle cycles between shutter fall and first shift (range 1..255).

Ports:
- readClk  in  1  readout clock; sole clock.
- resetN  in  1  asynchronous active-low reset.
- start  in  1  frame request; sampled only in IDLE.
- abort  in  1  cancel current frame; highest priority after reset.
- shutterLen  in  SHUT_W  exposure length in readClk cycles; 0 treated as 1.
- sumModeCfg  in  1  sum mode for next frame; latched on accepted start.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse at frame completion.
- shutter  out  1  to array shutter.
- sumMode  out  1  to array sumMode; latched value.
- shiftEn  out  1  array shift enable; array chains advance on a readClk edge where shiftEn=1.
- SerInA, SerInB  out  Col  fill data into chain inputs.
- SerOutA, SerOutB  in  Col  chain outputs from array.
- outData  out  2*Col  {SerOutB,SerOutA} captured beat.
- outValid  out  1  outData valid.
- outReady  in  1  downstream accept.
- outLast  out  1  high with final beat (beat N-1) of frame.

Behaviour:
- Reset (resetN=0, async):
  - State goes to IDLE.
  - shutter, shiftEn, outValid, outLast, done, busy = 0.
  - sumMode = 0; outData = 0; all counters = 0.
- FSM states: IDLE, EXPOSE, SETTLE, SHIFT, DRAIN, DONE.
- IDLE:
  - start=1 goes to EXPOSE next edge.
  - Latch sumMode <= sumModeCfg and expLen <= max(shutterLen,1).
- EXPOSE:
  - shutter=1 for exactly expLen cycles.
  - First shutter-high cycle is the cycle after start was sampled.
  - Then goes to SETTLE.
- SETTLE:
  - shutter=0 for SETTLE cycles, then goes to SHIFT with beatCnt=0.
- SHIFT:
  - Beat fires when (!outValid || outReady). On a firing cycle:
    - shiftEn=1 (combinational).
    - outData <= {SerOutB,SerOutA} sampled before the shift.
    - outValid <= 1.
    - outLast <= (beatCnt==N-1).
    - beatCnt++.
  - If outValid && !outReady: shiftEn=0, outData held stable.
  - After beat N-1 fires, go to DRAIN.
- DRAIN:
  - Wait until outValid && outReady, then clear outValid and outLast and go to DONE.
- DONE:
  - done=1 for one cycle, then go to IDLE.
- Stream rules:
  - outValid deasserts only on handshake (except abort/reset).
  - Back-to-back beats occur when outReady stays 1, so an unstalled frame transfers N beats in N cycles.
- abort in any non-IDLE state, at next edge:
  - Go to IDLE with shutter=0, shiftEn=0, outValid=0, outLast=0.
  - No done pulse.
  - Partial frame is discarded; the array chains are left partially shifted, and the next frame's exposure overwrites them.
- start while busy is ignored. start and abort both high in IDLE: abort wins, no frame starts.
- SerInA/SerInB = 0 in all states unless the optional feature is compiled in.
- Counters:
  - beatCnt width is $clog2(N+1); expCnt width is SHUT_W; no wrap is possible.
  - shutterLen=2^SHUT_W-1 is legal.

Optional Feature:
- Macro: PATTERN_INJECT_EN.
- When defined: during SHIFT firing cycles, SerInA = {Col{beatCnt[0]}} and SerInB = ~SerInA. After Row*CNT_W beats the chains hold a known alternating pattern; a second frame with zero exposure reads it back for chain integrity checking.
- When undefined: SerInA/SerInB tied to 0.

Test Plan:
- Basic frame (Row=3, Col=3, CNT_W=12; shutterLen=5, outReady=1):
  - shutter high exactly 5 cycles, then 4 idle cycles.
  - 36 consecutive beats, outLast on beat 35 only.
  - done pulse 2 cycles after the final beat fires (DRAIN, then DONE).
  - busy low after that.
- shutterLen=0 -> shutter high exactly 1 cycle; frame otherwise identical.
- Backpressure: outReady toggles 1,0,0,1 repeating.
  - shiftEn=0 and outData stable on every stalled cycle.
  - Exactly 36 beats accepted; array shifted exactly 36 times.
- Abort during SHIFT after beat 10:
  - Next cycle: outValid=0, shiftEn=0, busy=0, no done.
  - A following start runs a full 36-beat frame.
- Async reset mid-EXPOSE (resetN low for 3 ns between edges): shutter drops immediately without a clock, and all outputs go to reset values.
- PATTERN_INJECT_EN: frame 1, then frame 2 with shutterLen=1 and no hits:
  - Frame 2 beat k: outData[Col-1:0] = {Col{k[0]}} and outData[2*Col-1:Col] = its inverse.
  - sumMode tracks sumModeCfg captured at each start.
